// File: rtl/int_ctrl_if.sv
// Bus between the interrupt controller and its CPU/device side: request lines,
// mask write port, acknowledge/EOI handshake and the registered controller outputs.
interface int_ctrl_if;
    logic [7:0] irq;
    logic       mask_we;
    logic [7:0] mask_wdata;
    logic       eoi;
    logic       inta;
    logic       intr;
    logic [7:0] vector;
    logic [7:0] isr;

    modport master (
        output irq, mask_we, mask_wdata, eoi, inta,
        input  intr, vector, isr
    );

    modport slave (
        input  irq, mask_we, mask_wdata, eoi, inta,
        output intr, vector, isr
    );
endinterface

// File: rtl/int_ctrl.sv
// 8-line edge-triggered priority interrupt controller (bit 0 highest) with mask, ISR and INTA/EOI handshake.
// Optional nesting of higher-priority requests is enabled by defining INT_CTRL_NEST_EN.
module int_ctrl #(
    parameter logic [4:0]  VEC_BASE = 5'b01010,
    parameter int unsigned IRQ_SYNC = 1
) (
    input logic       clk,
    input logic       clr,
    int_ctrl_if.slave bus
);

    typedef enum logic [1:0] {IDLE, REQ, ACK, SERV} state_t;

    state_t     state;
    logic [7:0] irq_s;
    logic [7:0] irq_prev;
    logic [7:0] rise;
    logic [7:0] pending;
    logic [7:0] pending_n;
    logic [7:0] mask;
    logic [7:0] isr_r;
    logic [7:0] isr_n;
    logic [7:0] req_vec;
    logic [7:0] req_now;
    logic [7:0] pend_clr;
    logic [7:0] isr_set;
    logic [7:0] vector_r;
    logic [2:0] win_idx;
    logic       intr_r;
    logic       inta_d;
    logic       inta_rise;
    logic       ack_ok;
    logic       eligible;

    function automatic logic [2:0] low_idx(input logic [7:0] v);
        logic found;
        low_idx = '0;
        found   = 1'b0;
        for (int unsigned i = 0; i < 8; i++) begin
            if (v[i] && !found) begin
                low_idx = i[2:0];
                found   = 1'b1;
            end
        end
    endfunction

    generate
        if (IRQ_SYNC != 0) begin : g_sync
            logic [7:0] sync1;
            logic [7:0] sync2;
            always_ff @(posedge clk or posedge clr) begin
                if (clr) begin
                    sync1 <= '0;
                    sync2 <= '0;
                end else begin
                    sync1 <= bus.irq;
                    sync2 <= sync1;
                end
            end
            assign irq_s = sync2;
        end else begin : g_nosync
            assign irq_s = bus.irq;
        end
    endgenerate

    assign rise      = irq_s & ~irq_prev;
    assign inta_rise = bus.inta & ~inta_d;
    // Acknowledge arbitrates on latched pending only; request raising includes this cycle's edges.
    assign req_vec   = pending & ~mask;
    assign req_now   = (pending | rise) & ~mask;
    assign win_idx   = low_idx(req_vec);
    assign ack_ok    = (state == REQ) && inta_rise && (req_vec != '0);

`ifdef INT_CTRL_NEST_EN
    assign eligible = (req_now != '0) &&
                      ((isr_r == '0) || (low_idx(req_now) < low_idx(isr_r)));
`else
    assign eligible = (req_now != '0) && (isr_r == '0);
`endif

    always_comb begin
        pend_clr = '0;
        isr_set  = '0;
        if (ack_ok) begin
            pend_clr[win_idx] = 1'b1;
            isr_set[win_idx]  = 1'b1;
        end
        // A fresh edge on the winning line re-sets its pending bit.
        pending_n = (pending & ~pend_clr) | rise;
        // isr & (isr - 1) drops the lowest set bit; a no-op when isr is zero.
        isr_n     = (bus.eoi ? (isr_r & (isr_r - 8'd1)) : isr_r) | isr_set;
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state    <= IDLE;
            pending  <= '0;
            mask     <= '1;
            isr_r    <= '0;
            intr_r   <= 1'b0;
            vector_r <= '0;
            inta_d   <= 1'b0;
            irq_prev <= '0;
        end else begin
            irq_prev <= irq_s;
            inta_d   <= bus.inta;
            pending  <= pending_n;
            isr_r    <= isr_n;
            if (bus.mask_we) begin
                mask <= bus.mask_wdata;
            end
            case (state)
                IDLE: begin
                    if (eligible && !bus.inta) begin
                        state  <= REQ;
                        intr_r <= 1'b1;
                    end else if (isr_r != '0) begin
                        state <= SERV;
                    end
                end
                REQ: begin
                    if (inta_rise) begin
                        intr_r <= 1'b0;
                        if (ack_ok) begin
                            vector_r <= {VEC_BASE, win_idx};
                            state    <= ACK;
                        end else begin
                            vector_r <= {VEC_BASE, 3'b111};
                            state    <= IDLE;
                        end
                    end
                end
                ACK: begin
                    if (!bus.inta) begin
                        state <= SERV;
                    end
                end
                SERV: begin
                    if (isr_r == '0) begin
                        state <= IDLE;
                    end else if (eligible && !bus.inta) begin
                        state  <= REQ;
                        intr_r <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.intr   = intr_r;
    assign bus.vector = vector_r;
    assign bus.isr    = isr_r;

endmodule

// File: tb/tb_int_ctrl.sv
// Directed bench for int_ctrl: cycle-accurate vector table plus hand-written
// sequences for masking, spurious acknowledge, nesting and reset mid-handshake.
module tb_int_ctrl;

    typedef struct {
        logic       mwe;
        logic [7:0] mwd;
        logic [7:0] irq;
        logic       eoi;
        logic       inta;
        logic       eintr;
        logic [7:0] evec;
        logic [7:0] eisr;
    } vec_t;

    logic clk;
    logic clr;
    int   total;
    int   bad;

    int_ctrl_if bus();

    int_ctrl #(
        .VEC_BASE(5'b01010),
        .IRQ_SYNC(1)
    ) dut (
        .clk(clk),
        .clr(clr),
        .bus(bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        bus.irq        = '0;
        bus.mask_we    = 1'b0;
        bus.mask_wdata = '0;
        bus.eoi        = 1'b0;
        bus.inta       = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        clr = 1'b1;
        tick();
        tick();
        clr = 1'b0;
    endtask

    task automatic wait_intr(input int max_cycles);
        for (int i = 0; i < max_cycles; i++) begin
            if (bus.intr) break;
            tick();
        end
    endtask

    task automatic write_mask(input logic [7:0] m);
        bus.mask_we    = 1'b1;
        bus.mask_wdata = m;
        tick();
        bus.mask_we    = 1'b0;
    endtask

    vec_t tbl[23];

    initial begin
        total = 0;
        bad   = 0;
        idle_inputs();
        clr = 1'b1;

        // mwe mwd irq eoi inta | intr vec isr
        tbl[0]  = '{1'b1, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00};
        tbl[1]  = '{1'b0, 8'h00, 8'h20, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00};
        tbl[2]  = '{1'b0, 8'h00, 8'h20, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00};
        tbl[3]  = '{1'b0, 8'h00, 8'h20, 1'b0, 1'b0, 1'b1, 8'h00, 8'h00};
        tbl[4]  = '{1'b0, 8'h00, 8'h20, 1'b0, 1'b1, 1'b0, 8'h55, 8'h20};
        tbl[5]  = '{1'b0, 8'h00, 8'h20, 1'b0, 1'b0, 1'b0, 8'h55, 8'h20};
        tbl[6]  = '{1'b0, 8'h00, 8'h20, 1'b1, 1'b0, 1'b0, 8'h55, 8'h00};
        tbl[7]  = '{1'b0, 8'h00, 8'h20, 1'b0, 1'b0, 1'b0, 8'h55, 8'h00};
        tbl[8]  = '{1'b0, 8'h00, 8'h64, 1'b0, 1'b0, 1'b0, 8'h55, 8'h00};
        tbl[9]  = '{1'b0, 8'h00, 8'h64, 1'b0, 1'b0, 1'b0, 8'h55, 8'h00};
        tbl[10] = '{1'b0, 8'h00, 8'h64, 1'b0, 1'b0, 1'b1, 8'h55, 8'h00};
        tbl[11] = '{1'b0, 8'h00, 8'h64, 1'b0, 1'b1, 1'b0, 8'h52, 8'h04};
        tbl[12] = '{1'b0, 8'h00, 8'h64, 1'b0, 1'b0, 1'b0, 8'h52, 8'h04};
        tbl[13] = '{1'b0, 8'h00, 8'h64, 1'b1, 1'b0, 1'b0, 8'h52, 8'h00};
        tbl[14] = '{1'b0, 8'h00, 8'h64, 1'b0, 1'b0, 1'b0, 8'h52, 8'h00};
        tbl[15] = '{1'b0, 8'h00, 8'h64, 1'b0, 1'b0, 1'b1, 8'h52, 8'h00};
        tbl[16] = '{1'b0, 8'h00, 8'h64, 1'b0, 1'b1, 1'b0, 8'h56, 8'h40};
        tbl[17] = '{1'b0, 8'h00, 8'h64, 1'b0, 1'b0, 1'b0, 8'h56, 8'h40};
        tbl[18] = '{1'b0, 8'h00, 8'h64, 1'b1, 1'b0, 1'b0, 8'h56, 8'h00};
        tbl[19] = '{1'b0, 8'h00, 8'h64, 1'b0, 1'b0, 1'b0, 8'h56, 8'h00};
        tbl[20] = '{1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 8'h56, 8'h00};
        tbl[21] = '{1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 8'h56, 8'h00};
        tbl[22] = '{1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 8'h56, 8'h00};

        // Reset state
        tick();
        chk("rst_intr", {7'b0, bus.intr}, 8'h00);
        chk("rst_vector", bus.vector, 8'h00);
        chk("rst_isr", bus.isr, 8'h00);
        tick();
        clr = 1'b0;

        // Basic request/ack/eoi and two simultaneous requests
        for (int i = 0; i < 23; i++) begin
            bus.mask_we    = tbl[i].mwe;
            bus.mask_wdata = tbl[i].mwd;
            bus.irq        = tbl[i].irq;
            bus.eoi        = tbl[i].eoi;
            bus.inta       = tbl[i].inta;
            tick();
            chk($sformatf("tbl%0d_intr", i), {7'b0, bus.intr}, {7'b0, tbl[i].eintr});
            chk($sformatf("tbl%0d_vector", i), bus.vector, tbl[i].evec);
            chk($sformatf("tbl%0d_isr", i), bus.isr, tbl[i].eisr);
        end

        // Masked line held, fires after unmask; inta in IDLE ignored
        do_reset();
        bus.inta = 1'b1;
        tick();
        bus.inta = 1'b0;
        chk("idle_inta_vector", bus.vector, 8'h00);
        chk("idle_inta_intr", {7'b0, bus.intr}, 8'h00);
        tick();
        bus.irq = 8'h08;
        write_mask(8'h08);
        repeat (5) tick();
        chk("masked_intr", {7'b0, bus.intr}, 8'h00);
        write_mask(8'h00);
        wait_intr(4);
        chk("unmask_intr", {7'b0, bus.intr}, 8'h01);
        bus.inta = 1'b1;
        tick();
        chk("unmask_vector", bus.vector, 8'h53);
        chk("unmask_isr", bus.isr, 8'h08);
        bus.inta = 1'b0;

        // Spurious acknowledge, pending retained, mask write racing ack
        do_reset();
        bus.irq = 8'h10;
        write_mask(8'h00);
        wait_intr(6);
        chk("spur_intr", {7'b0, bus.intr}, 8'h01);
        write_mask(8'hFF);
        bus.inta = 1'b1;
        tick();
        chk("spur_vector", bus.vector, 8'h57);
        chk("spur_isr", bus.isr, 8'h00);
        chk("spur_intr_low", {7'b0, bus.intr}, 8'h00);
        bus.inta = 1'b0;
        repeat (3) tick();
        chk("spur_idle_intr", {7'b0, bus.intr}, 8'h00);
        write_mask(8'h00);
        wait_intr(4);
        chk("spur_retained_intr", {7'b0, bus.intr}, 8'h01);
        bus.mask_we    = 1'b1;
        bus.mask_wdata = 8'hFF;
        bus.inta       = 1'b1;
        tick();
        bus.mask_we = 1'b0;
        chk("oldmask_vector", bus.vector, 8'h54);
        chk("oldmask_isr", bus.isr, 8'h10);
        bus.inta = 1'b0;
        tick();

        // Higher-priority request while in service
        do_reset();
        bus.irq = 8'h10;
        write_mask(8'h00);
        wait_intr(6);
        bus.inta = 1'b1;
        tick();
        chk("nest_first_vector", bus.vector, 8'h54);
        chk("nest_first_isr", bus.isr, 8'h10);
        bus.inta = 1'b0;
        tick();
        bus.irq = 8'h12;
`ifdef INT_CTRL_NEST_EN
        wait_intr(6);
        chk("nest_intr", {7'b0, bus.intr}, 8'h01);
        bus.inta = 1'b1;
        tick();
        chk("nest_vector", bus.vector, 8'h51);
        chk("nest_isr", bus.isr, 8'h12);
        bus.inta = 1'b0;
        tick();
        bus.eoi = 1'b1;
        tick();
        bus.eoi = 1'b0;
        chk("nest_eoi_isr", bus.isr, 8'h10);
`else
        repeat (6) tick();
        chk("nonest_intr", {7'b0, bus.intr}, 8'h00);
        bus.eoi = 1'b1;
        tick();
        bus.eoi = 1'b0;
        chk("nonest_eoi_isr", bus.isr, 8'h00);
        wait_intr(6);
        chk("nonest_late_intr", {7'b0, bus.intr}, 8'h01);
        bus.inta = 1'b1;
        tick();
        chk("nonest_vector", bus.vector, 8'h51);
        chk("nonest_isr", bus.isr, 8'h02);
        bus.inta = 1'b0;
`endif
        tick();

        // Asynchronous reset during ACK
        do_reset();
        bus.irq = 8'h08;
        write_mask(8'h00);
        wait_intr(6);
        bus.inta = 1'b1;
        tick();
        chk("ack_vector", bus.vector, 8'h53);
        #3;
        clr = 1'b1;
        #1;
        chk("clr_intr", {7'b0, bus.intr}, 8'h00);
        chk("clr_vector", bus.vector, 8'h00);
        chk("clr_isr", bus.isr, 8'h00);
        tick();
        clr      = 1'b0;
        bus.inta = 1'b0;
        repeat (6) tick();
        chk("clr_mask_intr", {7'b0, bus.intr}, 8'h00);
        write_mask(8'h00);
        wait_intr(4);
        chk("clr_pending_intr", {7'b0, bus.intr}, 8'h01);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/int_ctrl.md
INT_CTRL -- requirements
Module: int_ctrl

Interface
REQ-001 Parameter VEC_BASE, default 5'b01010, upper five bits of every vector issued.
REQ-002 Parameter IRQ_SYNC, default 1, 1 = two-flop synchronizer on irq, 0 = irq sampled directly.
REQ-003 clk  input  1  sole clock, all state on rising edge.
REQ-004 clr  input  1  reset, asynchronous, active-high.
REQ-005 irq  input  8  device request lines, rising-edge sensitive, bit 0 highest priority.
REQ-006 mask_we  input  1  one-cycle strobe writing mask_wdata into mask register.
REQ-007 mask_wdata  input  8  new mask, 1 = line masked.
REQ-008 eoi  input  1  one-cycle end-of-interrupt strobe from CPU.
REQ-009 inta  input  1  CPU acknowledge, level, rising edge = acknowledge.
REQ-010 intr  output  1  interrupt request to CPU, registered.
REQ-011 vector  output  8  {VEC_BASE, id[2:0]}, registered, valid from cycle after inta rise.
REQ-012 isr  output  8  in-service register, debug visibility.

Function
REQ-013 Pending bit n SHALL set the cycle after a 0->1 edge of (synchronized) irq[n], independent of mask.
REQ-014 Mask SHALL gate request only; masked pending bits SHALL be retained and fire once unmasked.
REQ-015 FSM states IDLE, REQ, ACK, SERV.
REQ-016 IDLE->REQ when (pending & ~mask) != 0 and interrupts are eligible (REQ-024); intr=1 in REQ.
REQ-017 REQ->ACK on inta rising edge (inta=1, inta_d=0); winner = lowest index of (pending & ~mask) in that cycle, not the one that raised intr.
REQ-018 On REQ->ACK transition: vector <= {VEC_BASE, winner}, pending[winner] cleared, isr[winner] set, intr <= 0.
REQ-019 If no unmasked pending bit at inta rise: vector <= {VEC_BASE, 3'b111} (spurious), isr unchanged, next state IDLE.
REQ-020 ACK->SERV when inta returns to 0; vector SHALL hold until next acknowledge.
REQ-021 eoi SHALL clear the lowest-index set isr bit; eoi with isr==0 SHALL be ignored.
REQ-022 SERV->IDLE when isr becomes 0.
REQ-023 New irq edge and pending clear on same bit same cycle: set wins (bit stays 1).
REQ-024 Eligibility: without nesting (REQ-029) only when isr==0.
REQ-025 mask_we and acknowledge in same cycle: winner computed with old mask; new mask effective next cycle.
REQ-026 inta rising while not in REQ SHALL be ignored; intr never re-asserts before inta low.

Reset
REQ-027 clr asserted: pending=0, mask=8'hFF, isr=0, intr=0, vector=8'h00, state=IDLE, sync/edge flops=0, immediately, irrespective of clk.
REQ-028 Reset mid-handshake SHALL abandon the acknowledge; no vector or isr change survives reset.

Configuration
REQ-029 With INT_CTRL_NEST_EN defined: SERV->REQ allowed when an unmasked pending line has strictly lower index than lowest set isr bit; multiple isr bits may be set.
REQ-030 Without INT_CTRL_NEST_EN: at most one isr bit set; intr stays 0 until isr==0.

Verification
REQ-031 Reset, mask_wdata=8'h00, irq[5] rises -> intr=1 within 3 cycles (IRQ_SYNC=1); inta pulse -> vector=8'h55, isr=8'h20, intr=0.
REQ-032 irq[6] and irq[2] rise same cycle -> first ack vector=8'h52; after eoi second ack vector=8'h56.
REQ-033 mask=8'h08, irq[3] rises -> intr stays 0; mask=8'h00 -> intr=1, ack vector=8'h53.
REQ-034 intr=1 for irq[4], mask set to 8'hFF before inta -> spurious vector=8'h57, isr=0, FSM IDLE.
REQ-035 In service of irq[4], irq[1] rises -> with INT_CTRL_NEST_EN intr=1, ack vector=8'h51, isr=8'h12; without it intr=0 until eoi.
REQ-036 clr asserted during ACK -> intr=0, vector=8'h00, isr=0, mask=8'hFF same cycle.
